// File: rtl/dvp_capture.sv
// DVP camera capture: generates xclk, oversamples the sensor bus, packs byte pairs into
// RGB565 pixels tagged with x/y/sof/eol and streams them out through a show-ahead FIFO.
module dvp_capture #(
    parameter int XCLK_DIV   = 4,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        single,
    input  logic        clr_ovf,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic        pclk,
    input  logic [7:0]  cam_data,
    output logic        xclk,
    output logic        cam_shutter,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] frame_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(XCLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(XCLK_DIV / 2 - 1);
    localparam logic [9:0]    X_MAX   = 10'(H_ACTIVE - 1);
    localparam logic [8:0]    Y_MAX   = 9'(V_ACTIVE - 1);
    localparam logic [AW:0]   FULL    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAITF, ACTIVE, DONE} state_t;

    state_t        state_q, state_d;
    logic [10:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]    prev_q, prev_d;
    logic [CW-1:0] xcnt_q, xcnt_d;
    logic          xclk_q, xclk_d, shutter_q, shutter_d;
    logic          single_q, single_d, phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic          held_vld_q, held_vld_d;
    logic [35:0]   held_q, held_d;
    logic [15:0]   fc_q, fc_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [36:0]   mem_q [FIFO_DEPTH];

    logic          s_vsync, s_href, s_pclk;
    logic [7:0]    s_data;
    logic          pclk_rise, href_fall, vsync_rise, vsync_fall;
    logic          push, pop, full, wr_ok, drop;
    logic [36:0]   push_entry;

    assign {s_vsync, s_href, s_pclk, s_data} = sync2_q;
    assign pclk_rise  = s_pclk & ~prev_q[0];
    assign href_fall  = ~s_href & prev_q[1];
    assign vsync_rise = s_vsync & ~prev_q[2];
    assign vsync_fall = ~s_vsync & prev_q[2];

    assign busy        = (state_q != IDLE);
    assign xclk        = xclk_q;
    assign cam_shutter = shutter_q;
    assign overflow    = ovf_q;
    assign frame_count = fc_q;
    assign pix_valid   = (count_q != '0);
    assign {pix_data, pix_x, pix_y, pix_sof, pix_eol} = pix_valid ? mem_q[rd_q] : '0;

    always_comb begin
        // All four bus signals share one synchronizer so they stay cycle-aligned.
        sync1_d   = {cam_vsync, cam_href, pclk, cam_data};
        sync2_d   = sync1_q;
        prev_d    = {s_vsync, s_href, s_pclk};
        shutter_d = ~(enable | busy);
        xcnt_d    = '0;
        xclk_d    = 1'b0;
        if (enable | busy) begin
            if (xcnt_q == HALF_M1) begin
                xcnt_d = '0;
                xclk_d = ~xclk_q;
            end else begin
                xcnt_d = xcnt_q + 1'b1;
                xclk_d = xclk_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        single_d   = single_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        x_d        = x_q;
        y_d        = y_q;
        held_vld_d = held_vld_q;
        held_d     = held_q;
        fc_d       = fc_q;
        push       = 1'b0;
        push_entry = '0;
        case (state_q)
            IDLE:  if (enable) state_d = WAITF;
            WAITF: begin
                if (!enable) state_d = IDLE;
                else if (vsync_fall) begin
                    state_d  = ACTIVE;
                    single_d = single;
                    phase_d  = 1'b0;
                    x_d      = '0;
                    y_d      = '0;
                end
            end
            ACTIVE: begin
                if (vsync_rise) begin
                    fc_d    = fc_q + 1'b1;
                    state_d = single_q ? DONE : (enable ? WAITF : IDLE);
                end
                if (pclk_rise && s_href) begin
                    if (!phase_q) begin
                        hi_d    = s_data;
                        phase_d = 1'b1;
                    end else begin
                        // Each pixel waits in the held register so the line end can tag it eol.
                        if (held_vld_q) begin
                            push       = 1'b1;
                            push_entry = {held_q, 1'b0};
                        end
                        held_d     = {hi_q, s_data, x_q, y_q, (x_q == '0 && y_q == '0)};
                        held_vld_d = 1'b1;
                        phase_d    = 1'b0;
                        if (x_q != X_MAX) x_d = x_q + 1'b1;
                    end
                end else if (href_fall) begin
                    if (held_vld_q) begin
                        push       = 1'b1;
                        push_entry = {held_q, 1'b1};
                        held_vld_d = 1'b0;
                    end
                    phase_d = 1'b0;
                    x_d     = '0;
                    if (y_q != Y_MAX) y_d = y_q + 1'b1;
                end
            end
            DONE:    if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop   = pix_valid & pix_ready;
        full  = (count_q == FULL);
        wr_ok = push & (~full | pop);
        drop  = push & full & ~pop;
        ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
        wr_d  = wr_ok ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q;
        if (wr_ok && !pop)      count_d = count_q + 1'b1;
        else if (!wr_ok && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            xcnt_q     <= '0;
            xclk_q     <= 1'b0;
            shutter_q  <= 1'b1;
            single_q   <= 1'b0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            held_vld_q <= 1'b0;
            held_q     <= '0;
            fc_q       <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            xcnt_q     <= xcnt_d;
            xclk_q     <= xclk_d;
            shutter_q  <= shutter_d;
            single_q   <= single_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            x_q        <= x_d;
            y_q        <= y_d;
            held_vld_q <= held_vld_d;
            held_q     <= held_d;
            fc_q       <= fc_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_q] <= push_entry;
    end
endmodule

// File: tb/tb_dvp_capture.sv
// Bench for dvp_capture: a DVP sensor BFM drives frames, a frame-level model predicts the
// pixel stream, and a monitor collects every valid&ready transfer for comparison.
module tb_dvp_capture;
    localparam int H = 640;
    localparam int V = 480;

    logic        clk = 1'b0;
    logic        reset, enable, single, clr_ovf, cam_vsync, cam_href, pclk, pix_ready;
    logic [7:0]  cam_data;
    logic        xclk, cam_shutter, pix_sof, pix_eol, pix_valid, busy, overflow;
    logic [15:0] pix_data, frame_count;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;

    typedef struct packed {
        logic [15:0] d;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        sof;
        logic        eol;
    } pix_t;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_d;
        int          exp_x;
        logic        exp_eol;
    } vec_t;

    pix_t       got_q[$], exp_q[$];
    logic [7:0] fb[$];
    int         fl[$];
    int         n_pass = 0, n_total = 0, fc_exp = 0;
    int         rmode = 1;

    dvp_capture dut (
        .clk(clk), .reset(reset), .enable(enable), .single(single), .clr_ovf(clr_ovf),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .pclk(pclk), .cam_data(cam_data),
        .xclk(xclk), .cam_shutter(cam_shutter), .pix_data(pix_data), .pix_x(pix_x),
        .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .busy(busy), .overflow(overflow), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rmode == 2) pix_ready = ($urandom_range(0, 1) == 1);
        else            pix_ready = (rmode == 1);
    end

    always @(negedge clk) begin
        if (pix_valid && pix_ready) got_q.push_back({pix_data, pix_x, pix_y, pix_sof, pix_eol});
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Sensor BFM: vsync high = blanking; bytes change with pclk low, sampled on its rise.
    task automatic run_frame();
        int p = 0;
        cam_vsync = 1'b1; cam_href = 1'b0; pclk = 1'b0;
        tick(6);
        cam_vsync = 1'b0;
        tick(6);
        foreach (fl[li]) begin
            cam_href = 1'b1;
            for (int b = 0; b < fl[li]; b++) begin
                cam_data = fb[p];
                p++;
                pclk = 1'b0; tick(2);
                pclk = 1'b1; tick(2);
            end
            pclk = 1'b0; tick(2);
            cam_href = 1'b0; tick(8);
        end
        cam_vsync = 1'b1;
        tick(6);
    endtask

    // Expected stream: floor(len/2) pixels per line, last one of each line tagged eol.
    task automatic model_frame();
        int p = 0;
        foreach (fl[li]) begin
            int n = fl[li] / 2;
            for (int k = 0; k < n; k++) begin
                pix_t e;
                e.d   = {fb[p + 2 * k], fb[p + 2 * k + 1]};
                e.x   = 10'((k > H - 1) ? H - 1 : k);
                e.y   = 9'((li > V - 1) ? V - 1 : li);
                e.sof = (k == 0 && li == 0);
                e.eol = (k == n - 1);
                exp_q.push_back(e);
            end
            p += fl[li];
        end
    endtask

    task automatic compare(input string tag);
        for (int i = 0; i < 2000 && got_q.size() < exp_q.size(); i++) tick(1);
        tick(4);
        check({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            pix_t e, g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check($sformatf("%s pix x%0d y%0d", tag, e.x, e.y), 64'(g), 64'(e));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        vec_t tbl[4];
        logic s[16];
        int   bad, highs, lat;
        logic [15:0] d0;

        tbl[0] = '{8'hF8, 8'h1F, 16'hF81F, 0, 1'b0};
        tbl[1] = '{8'h00, 8'hFF, 16'h00FF, 1, 1'b0};
        tbl[2] = '{8'h12, 8'h34, 16'h1234, 2, 1'b0};
        tbl[3] = '{8'hA5, 8'h5A, 16'hA55A, 3, 1'b1};

        reset = 1'b1; enable = 1'b0; single = 1'b0; clr_ovf = 1'b0;
        cam_vsync = 1'b1; cam_href = 1'b0; pclk = 1'b0; cam_data = 8'h00; pix_ready = 1'b1;
        tick(3);
        check("rst xclk", 64'(xclk), 0);
        check("rst shutter", 64'(cam_shutter), 1);
        check("rst valid", 64'(pix_valid), 0);
        check("rst busy", 64'(busy), 0);
        check("rst overflow", 64'(overflow), 0);
        check("rst frame_count", 64'(frame_count), 0);
        check("rst pix_data", 64'(pix_data), 0);
        reset = 1'b0;
        highs = 0;
        for (int i = 0; i < 10; i++) begin tick(1); highs += int'(xclk); end
        check("idle xclk highs", 64'(highs), 0);

        // xclk: every sample equals the inverse of the one two cycles earlier -> 2 high/2 low
        enable = 1'b1;
        tick(3);
        check("shutter enabled", 64'(cam_shutter), 0);
        for (int i = 0; i < 16; i++) begin s[i] = xclk; tick(1); end
        bad = 0; highs = 0;
        for (int i = 0; i < 14; i++) if (s[i + 2] == s[i]) bad++;
        for (int i = 0; i < 16; i++) highs += int'(s[i]);
        check("xclk period", 64'(bad), 0);
        check("xclk duty", 64'(highs), 8);

        // 4 lines x 4 pixels
        fb.delete(); fl.delete();
        for (int i = 0; i < 32; i++) fb.push_back(8'(i * 13 + 5));
        for (int i = 0; i < 4; i++) fl.push_back(8);
        model_frame(); run_frame(); compare("frame4x4");
        fc_exp++;
        check("fc after frame4x4", 64'(frame_count), 64'(fc_exp));

        // table line plus a 7-byte line
        fb.delete(); fl.delete();
        for (int i = 0; i < 4; i++) begin fb.push_back(tbl[i].hi); fb.push_back(tbl[i].lo); end
        for (int i = 0; i < 7; i++) fb.push_back(8'(i + 100));
        fl.push_back(8); fl.push_back(7);
        run_frame(); tick(10);
        fc_exp++;
        check("table count", 64'(got_q.size()), 7);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            check($sformatf("tbl%0d data", i), 64'(got_q[i].d), 64'(tbl[i].exp_d));
            check($sformatf("tbl%0d x", i), 64'(got_q[i].x), 64'(tbl[i].exp_x));
            check($sformatf("tbl%0d eol", i), 64'(got_q[i].eol), 64'(tbl[i].exp_eol));
        end
        for (int k = 0; k < 3 && k + 4 < got_q.size(); k++) begin
            check($sformatf("odd%0d x", k), 64'(got_q[k + 4].x), 64'(k));
            check($sformatf("odd%0d y", k), 64'(got_q[k + 4].y), 1);
            check($sformatf("odd%0d eol", k), 64'(got_q[k + 4].eol), 64'(k == 2));
        end
        got_q.delete();

        // overflow: 12 pixels into an 8-deep FIFO with no drain
        rmode = 0; tick(3);
        fb.delete(); fl.delete();
        for (int i = 0; i < 24; i++) fb.push_back(8'(i * 7 + 3));
        fl.push_back(24);
        model_frame(); run_frame();
        fc_exp++;
        while (exp_q.size() > 8) void'(exp_q.pop_back());
        check("ovf set", 64'(overflow), 1);
        check("ovf valid", 64'(pix_valid), 1);
        d0 = pix_data;
        tick(3);
        check("hold data", 64'(pix_data), 64'({fb[0], fb[1]}));
        check("hold stable", 64'(pix_data), 64'(d0));
        check("hold x", 64'(pix_x), 0);
        rmode = 1;
        compare("ovf");
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0; tick(1);
        check("ovf cleared", 64'(overflow), 0);

        // latency: a one-pixel line is only pushed on the href fall
        rmode = 0; tick(3);
        fb.delete(); fl.delete();
        fb.push_back(8'h3C); fb.push_back(8'hC3); fl.push_back(2);
        model_frame();
        fork
            run_frame();
            begin
                @(negedge cam_href);
                lat = 0;
                while (!pix_valid && lat < 10) begin tick(1); lat++; end
                check($sformatf("latency %0d clk <= 6", lat), 64'(lat <= 6), 1);
            end
        join
        fc_exp++;
        rmode = 1;
        compare("latency");

        // single-shot: three frames, only the first captured
        single = 1'b1;
        fb.delete(); fl.delete();
        for (int i = 0; i < 4; i++) fb.push_back(8'(i + 200));
        fl.push_back(4);
        model_frame();
        repeat (3) run_frame();
        fc_exp++;
        compare("single");
        check("single fc", 64'(frame_count), 64'(fc_exp));
        check("single busy", 64'(busy), 1);
        enable = 1'b0; tick(1);
        check("done->idle busy", 64'(busy), 0);
        tick(1);
        check("idle shutter", 64'(cam_shutter), 1);
        highs = 0;
        for (int i = 0; i < 10; i++) begin tick(1); highs += int'(xclk); end
        check("idle xclk low", 64'(highs), 0);
        single = 1'b0;

        // enable dropped mid-frame: frame still completes
        enable = 1'b1; tick(2);
        fb.delete(); fl.delete();
        for (int i = 0; i < 24; i++) fb.push_back(8'($urandom));
        for (int i = 0; i < 3; i++) fl.push_back(8);
        model_frame();
        fork
            run_frame();
            begin tick(60); enable = 1'b0; end
        join
        fc_exp++;
        compare("enable drop");
        check("enable drop fc", 64'(frame_count), 64'(fc_exp));
        check("enable drop idle", 64'(busy), 0);

        // reset mid-line
        enable = 1'b1; rmode = 0; tick(2);
        fork
            run_frame();
            begin tick(30); reset = 1'b1; tick(2); reset = 1'b0; end
        join
        fc_exp = 0;
        check("mid rst valid", 64'(pix_valid), 0);
        check("mid rst fc", 64'(frame_count), 0);
        got_q.delete();
        rmode = 1;
        fb.delete(); fl.delete();
        for (int i = 0; i < 8; i++) fb.push_back(8'(i * 31));
        fl.push_back(4); fl.push_back(4);
        model_frame(); run_frame();
        fc_exp++;
        compare("after reset");
        check("after reset fc", 64'(frame_count), 64'(fc_exp));

        // randomized frames with random back-pressure
        rmode = 2;
        for (int f = 0; f < 5; f++) begin
            int nl;
            fb.delete(); fl.delete();
            nl = $urandom_range(1, 4);
            for (int l = 0; l < nl; l++) begin
                int len = $urandom_range(1, 9);
                fl.push_back(len);
                for (int b = 0; b < len; b++) fb.push_back(8'($urandom));
            end
            model_frame(); run_frame();
            fc_exp++;
            compare($sformatf("rand%0d", f));
        end
        check("rand fc", 64'(frame_count), 64'(fc_exp));
        check("rand no overflow", 64'(overflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
